// File: rtl/pll_phase_ctrl.sv
// Reset, lock qualification and dynamic phase/duty sequencing for the PSRAM rPLL.
// Runs entirely on the free-running reference clock; pll_lock is treated as asynchronous.
module pll_phase_ctrl #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int SETTLE_CYCLES       = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int DEFAULT_PHASE       = 4,
  parameter int DUTY_OFFSET         = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               pll_lock,
  input  logic                               restart,
  input  logic                               phase_valid,
  input  logic [3:0]                         phase_val,
  output logic                               phase_ready,
  output logic                               phase_done,
  output logic                               pll_reset,
  output logic [3:0]                         psda,
  output logic [3:0]                         dutyda,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
);

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      max2 = a;
    end else begin
      max2 = b;
    end
  endfunction

  localparam int CNT_MAX = max2(max2(RESET_CYCLES, LOCK_STABLE_CYCLES),
                                max2(LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RET_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);
  localparam logic [RET_W-1:0] RET_ZERO     = RET_W'(0);
  localparam logic [3:0]       PHASE_RST    = 4'(DEFAULT_PHASE);
  localparam logic [3:0]       DUTY_OFS     = 4'(DUTY_OFFSET);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // The 4-bit sum wraps modulo 16, matching the PLL's DUTYDA encoding.
  function automatic logic [3:0] duty_of(input logic [3:0] phase);
    duty_of = phase + DUTY_OFS;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_SAT) begin
      cnt_inc = c;
    end else begin
      cnt_inc = c + CNT_W'(1);
    end
  endfunction

  function automatic logic [RET_W-1:0] ret_inc(input logic [RET_W-1:0] r);
    if (r == RET_MAX) begin
      ret_inc = r;
    end else begin
      ret_inc = r + RET_W'(1);
    end
  endfunction

  logic             lock_meta_r;
  logic             lock_s_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [RET_W-1:0] retries_r;
  logic [RET_W-1:0] retries_nxt_s;
  logic [RET_W-1:0] retries_inc_s;

  logic             pll_reset_r;
  logic             ready_r;
  logic             fault_r;
  logic             lock_lost_r;
  logic             phase_done_r;
  logic [3:0]       psda_r;
  logic [3:0]       dutyda_r;

  logic             pll_reset_nxt_s;
  logic             ready_nxt_s;
  logic             fault_nxt_s;
  logic             lock_lost_nxt_s;
  logic             phase_done_nxt_s;
  logic [3:0]       psda_nxt_s;
  logic [3:0]       dutyda_nxt_s;

  logic             phase_ready_s;
  logic             accept_s;
  logic             lost_s;

  assign phase_ready_s = (state_r == ST_READY) && lock_s_r && !restart;
  assign accept_s      = phase_valid && phase_ready_s;
  assign lost_s        = !restart && !lock_s_r &&
                         ((state_r == ST_READY) || (state_r == ST_SETTLE));
  assign retries_inc_s = ret_inc(retries_r);

  // Two-flop synchroniser for the asynchronous LOCK input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_s_r    <= lock_meta_r;
    end
  end

  // State, shared sequencing counter and retry count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_RESET_PLL;
      cnt_r     <= CNT_ZERO;
      retries_r <= RET_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      retries_r <= retries_nxt_s;
    end
  end

  // Next-state, counter and retry decisions; restart overrides every state.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    retries_nxt_s = retries_r;
    if (restart) begin
      state_nxt_s   = ST_RESET_PLL;
      cnt_nxt_s     = CNT_ZERO;
      retries_nxt_s = RET_ZERO;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == RESET_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_inc(cnt_r);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_r) begin
            state_nxt_s = ST_STABLE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == TIMEOUT_LAST) begin
            retries_nxt_s = retries_inc_s;
            cnt_nxt_s     = CNT_ZERO;
            if (retries_inc_s == RET_MAX) begin
              state_nxt_s = ST_FAULT;
            end else begin
              state_nxt_s = ST_RESET_PLL;
            end
          end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
          end
        end
        ST_STABLE: begin
          // A single low sample restarts the lock wait without costing a retry.
          if (!lock_s_r) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s   = ST_READY;
            cnt_nxt_s     = CNT_ZERO;
            retries_nxt_s = RET_ZERO;
          end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
          end
        end
        ST_READY: begin
          if (!lock_s_r) begin
            state_nxt_s = ST_RESET_PLL;
            cnt_nxt_s   = CNT_ZERO;
          end else if (accept_s) begin
            state_nxt_s = ST_SETTLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_SETTLE: begin
          if (!lock_s_r) begin
            state_nxt_s = ST_RESET_PLL;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == SETTLE_LAST) begin
            state_nxt_s = ST_READY;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_RESET_PLL;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    pll_reset_nxt_s  = 1'b0;
    ready_nxt_s      = 1'b0;
    fault_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_RESET_PLL: pll_reset_nxt_s = 1'b1;
      ST_FAULT: begin
        pll_reset_nxt_s = 1'b1;
        fault_nxt_s     = 1'b1;
      end
      ST_READY:     ready_nxt_s     = 1'b1;
      default:      ready_nxt_s     = 1'b0;
    endcase
    lock_lost_nxt_s  = lost_s;
    phase_done_nxt_s = !restart && lock_s_r && (state_r == ST_SETTLE) &&
                       (cnt_r == SETTLE_LAST);
    if (accept_s) begin
      psda_nxt_s   = phase_val;
      dutyda_nxt_s = duty_of(phase_val);
    end else begin
      psda_nxt_s   = psda_r;
      dutyda_nxt_s = dutyda_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pll_reset_r  <= 1'b1;
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
      lock_lost_r  <= 1'b0;
      phase_done_r <= 1'b0;
      psda_r       <= PHASE_RST;
      dutyda_r     <= duty_of(PHASE_RST);
    end else begin
      pll_reset_r  <= pll_reset_nxt_s;
      ready_r      <= ready_nxt_s;
      fault_r      <= fault_nxt_s;
      lock_lost_r  <= lock_lost_nxt_s;
      phase_done_r <= phase_done_nxt_s;
      psda_r       <= psda_nxt_s;
      dutyda_r     <= dutyda_nxt_s;
    end
  end

  assign phase_ready = phase_ready_s;
  assign phase_done  = phase_done_r;
  assign pll_reset   = pll_reset_r;
  assign psda        = psda_r;
  assign dutyda      = dutyda_r;
  assign ready       = ready_r;
  assign fault       = fault_r;
  assign lock_lost   = lock_lost_r;
  assign retries     = retries_r;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Table-driven, scoreboard-checked bench for pll_phase_ctrl with short test-plan timings.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       restart;
  logic       phase_valid;
  logic [3:0] phase_val;
  logic       phase_ready;
  logic       phase_done;
  logic       pll_reset;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retries;

  pll_phase_ctrl #(
    .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
    .SETTLE_CYCLES(4), .MAX_RETRIES(2), .DEFAULT_PHASE(4), .DUTY_OFFSET(4)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .restart(restart),
    .phase_valid(phase_valid), .phase_val(phase_val), .phase_ready(phase_ready),
    .phase_done(phase_done), .pll_reset(pll_reset), .psda(psda), .dutyda(dutyda),
    .ready(ready), .fault(fault), .lock_lost(lock_lost), .retries(retries)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pll_reset;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic       phase_done;
    logic       phase_ready;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic [1:0] retries;
  } exp_t;

  typedef struct {
    int         n;
    logic       lock;
    logic       rst;
    logic       pv;
    logic [3:0] pval;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t ex(input logic prst, input logic rdy, input logic flt,
                              input logic ll, input logic pd, input logic pr,
                              input logic [3:0] ps, input logic [3:0] du,
                              input logic [1:0] rt);
    exp_t e;
    e.pll_reset = prst; e.ready = rdy; e.fault = flt; e.lock_lost = ll;
    e.phase_done = pd; e.phase_ready = pr; e.psda = ps; e.dutyda = du; e.retries = rt;
    return e;
  endfunction

  function automatic vec_t mk(input int n, input logic lk, input logic rs,
                              input logic pv, input logic [3:0] pval, input exp_t e);
    vec_t v;
    v.n = n; v.lock = lk; v.rst = rs; v.pv = pv; v.pval = pval; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string tag, input string sig,
                     input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, sig, act, expv);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "pll_reset",   4'(pll_reset),   4'(e.pll_reset));
      cmp(tag, "ready",       4'(ready),       4'(e.ready));
      cmp(tag, "fault",       4'(fault),       4'(e.fault));
      cmp(tag, "lock_lost",   4'(lock_lost),   4'(e.lock_lost));
      cmp(tag, "phase_done",  4'(phase_done),  4'(e.phase_done));
      cmp(tag, "phase_ready", 4'(phase_ready), 4'(e.phase_ready));
      cmp(tag, "psda",        psda,            e.psda);
      cmp(tag, "dutyda",      dutyda,          e.dutyda);
      cmp(tag, "retries",     4'(retries),     4'(e.retries));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    for (int k = 0; k < v.n; k++) begin
      pll_lock    = v.lock;
      restart     = v.rst;
      phase_valid = v.pv;
      phase_val   = v.pval;
      exp_q.push_back(v.e);
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("v%0d.c%0d", idx, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        n   lk rs pv val     rst rdy flt ll pd pr psda   duty   ret
    // power-up lock with pll_lock tied high
    tbl.push_back(mk(3,  1, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0)));
    tbl.push_back(mk(9,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0)));
    tbl.push_back(mk(3,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 1, 4'h4, 4'h8, 2'd0)));
    // phase E with duty wrap, then a same-value request
    tbl.push_back(mk(1,  1, 0, 1, 4'hE, ex(0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(3,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 1, 1, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(2,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 1, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 1, 4'hE, ex(0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(3,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 1, 1, 4'hE, 4'h2, 2'd0)));
    // lock drop during SETTLE
    tbl.push_back(mk(1,  1, 0, 1, 4'h3, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(2,  0, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  0, 0, 0, 4'h0, ex(1, 0, 0, 1, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(3,  0, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    // one-clock lock glitch after 5 good STABLE samples
    tbl.push_back(mk(6,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  0, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(10, 1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(2,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 1, 4'h3, 4'h7, 2'd0)));
    // lock loss coinciding with a request
    tbl.push_back(mk(1,  0, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 1, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  0, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  0, 0, 1, 4'h9, ex(1, 0, 0, 1, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(3,  0, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    // two timeouts into FAULT, then restart
    tbl.push_back(mk(32, 0, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(4,  0, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd1)));
    tbl.push_back(mk(32, 0, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd1)));
    tbl.push_back(mk(3,  0, 0, 0, 4'h0, ex(1, 0, 1, 0, 0, 0, 4'h3, 4'h7, 2'd2)));
    tbl.push_back(mk(1,  0, 1, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(3,  0, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    // relock, then a request left mid-SETTLE for the async reset check
    tbl.push_back(mk(1,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(9,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 0, 4'h0, ex(0, 1, 0, 0, 0, 1, 4'h3, 4'h7, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 1, 4'hC, ex(0, 0, 0, 0, 0, 0, 4'hC, 4'h0, 2'd0)));
    tbl.push_back(mk(1,  1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'hC, 4'h0, 2'd0)));

    resetn      = 1'b0;
    pll_lock    = 1'b1;
    restart     = 1'b0;
    phase_valid = 1'b0;
    phase_val   = 4'h0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(ex(1, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0));
    check_out("reset");
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // resetn asserted between clock edges must take effect without a clock
    #2;
    resetn = 1'b0;
    #1;
    exp_q.push_back(ex(1, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0));
    check_out("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    apply(mk(3, 1, 0, 0, 4'h0, ex(1, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0)), 100);
    apply(mk(1, 1, 0, 0, 4'h0, ex(0, 0, 0, 0, 0, 0, 4'h4, 4'h8, 2'd0)), 101);

    cmp("end", "queue_left", 4'(exp_q.size()), 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
